// File: rtl/noc_packet_checker.sv
`default_nettype none
// ============================================================================
//  Module   : noc_packet_checker
//  Purpose  : Receive-side sink for a NoC local port. Accepts header/data/tail
//             flits from the router ejection port and checks each packet for:
//               - destination equal to this node's ID,
//               - all-ones data flits,
//               - the exact number of data flits,
//               - a tail whose source field matches the header.
//             For each closed packet it reports a pass/fail pulse, the first
//             error code and the source ID. It also keeps saturating
//             good/bad/stray counters.
//  Ports    :
//    noc_clk, noc_rst          clock, synchronous active-high reset
//    receive_valid/ready       flit handshake (ready depends on state only)
//    receive_flit              flit payload, FLIT_W bits
//    receive_is_header/_tail   flit type qualifiers
//    pkt_done, pkt_err         one-cycle close pulse and its fail flag
//    err_code                  first error of the last closed packet
//    src_x, src_y              source of the last closed packet
//    good_num, bad_num         saturating packet counters
//    stray_num                 saturating count of flits dropped in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module noc_packet_checker #(
  parameter int FLIT_W    = 128,
  parameter int ID_X_W    = 4,
  parameter int ID_Y_W    = 4,
  parameter int MARK_W    = 8,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  parameter int EXP_DATA  = 11,
  parameter int STALL_CYC = 0
) (
  input  logic                noc_clk,
  input  logic                noc_rst,
  input  logic                receive_valid,
  output logic                receive_ready,
  input  logic [FLIT_W-1:0]   receive_flit,
  input  logic                receive_is_header,
  input  logic                receive_is_tail,
  output logic                pkt_done,
  output logic                pkt_err,
  output logic [2:0]          err_code,
  output logic [ID_X_W-1:0]   src_x,
  output logic [ID_Y_W-1:0]   src_y,
  output logic [7:0]          good_num,
  output logic [7:0]          bad_num,
  output logic [7:0]          stray_num
);

  localparam int ID_W    = ID_X_W + ID_Y_W;
  localparam int SRC_HI  = FLIT_W - MARK_W - 1;
  localparam int DEST_HI = SRC_HI - ID_W;

  localparam logic [ID_W-1:0] MY_ID = {MY_X[ID_X_W-1:0], MY_Y[ID_Y_W-1:0]};
  localparam logic [7:0] EXP_CNT    = EXP_DATA[7:0];
  localparam bit         HAS_STALL  = (STALL_CYC > 0);
  localparam bit         NEED_DATA  = (EXP_DATA > 0);
  // Stall counter counts down from STALL_CYC-1 to 0, so the STALL state
  // lasts exactly STALL_CYC cycles.
  localparam int         STALL_LOAD_I = (STALL_CYC > 0) ? (STALL_CYC - 1) : 0;
  localparam logic [7:0] STALL_LOAD   = STALL_LOAD_I[7:0];

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_DEST   = 3'd1;
  localparam logic [2:0] ERR_DATA   = 3'd2;
  localparam logic [2:0] ERR_SHORT  = 3'd3;
  localparam logic [2:0] ERR_LONG   = 3'd4;
  localparam logic [2:0] ERR_HDR    = 3'd5;
  localparam logic [2:0] ERR_TSRC   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BODY  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] src_lat;
  logic [7:0]      data_cnt;
  logic [2:0]      err_acc;
  logic [7:0]      stall_cnt;

  logic            xfer;
  logic [ID_W-1:0] flit_src;
  logic [ID_W-1:0] flit_dest;
  logic            dest_bad;
  logic            data_bad;
  logic            close_pkt;
  logic            open_pkt;
  logic            end_pkt;
  logic            data_flit;
  logic            stray_flit;
  logic [2:0]      close_code;
  logic [ID_W-1:0] close_src;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode what the current transfer does to the packet stream.
  always_comb begin
    xfer       = receive_valid && receive_ready;
    flit_src   = receive_flit[SRC_HI -: ID_W];
    flit_dest  = receive_flit[DEST_HI -: ID_W];
    dest_bad   = (flit_dest != MY_ID);
    data_bad   = ~&receive_flit;
    close_pkt  = 1'b0;
    open_pkt   = 1'b0;
    data_flit  = 1'b0;
    stray_flit = 1'b0;
    close_code = ERR_NONE;
    close_src  = src_lat;
    if (xfer) begin
      case (state)
        S_IDLE: begin
          if (receive_is_header) begin
            if (receive_is_tail) begin
              // Single-flit packet: the header is also its own tail.
              close_pkt = 1'b1;
              close_src = flit_src;
              if (dest_bad)
                close_code = ERR_DEST;
              else if (NEED_DATA)
                close_code = ERR_SHORT;
            end else begin
              open_pkt = 1'b1;
            end
          end else begin
            stray_flit = 1'b1;
          end
        end
        S_BODY: begin
          if (receive_is_header) begin
            // Close the current packet as bad; the same flit opens the next.
            close_pkt  = 1'b1;
            open_pkt   = 1'b1;
            close_code = (err_acc != ERR_NONE) ? err_acc : ERR_HDR;
          end else if (receive_is_tail) begin
            close_pkt = 1'b1;
            if (err_acc != ERR_NONE)
              close_code = err_acc;
            else if (data_cnt < EXP_CNT)
              close_code = ERR_SHORT;
            else if (flit_src != src_lat)
              close_code = ERR_TSRC;
          end else begin
            data_flit = 1'b1;
          end
        end
        default: ;
      endcase
    end
    end_pkt = close_pkt && !open_pkt;
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state         <= S_IDLE;
      receive_ready <= 1'b1;
      pkt_done      <= 1'b0;
      pkt_err       <= 1'b0;
      err_code      <= ERR_NONE;
      src_x         <= '0;
      src_y         <= '0;
      good_num      <= 8'd0;
      bad_num       <= 8'd0;
      stray_num     <= 8'd0;
      src_lat       <= '0;
      data_cnt      <= 8'd0;
      err_acc       <= ERR_NONE;
      stall_cnt     <= 8'd0;
    end else begin
      pkt_done <= close_pkt;

      if (close_pkt) begin
        pkt_err  <= (close_code != ERR_NONE);
        err_code <= close_code;
        src_x    <= close_src[ID_W-1 -: ID_X_W];
        src_y    <= close_src[ID_Y_W-1:0];
        if (close_code == ERR_NONE)
          good_num <= sat_inc(good_num);
        else
          bad_num  <= sat_inc(bad_num);
      end

      if (open_pkt) begin
        src_lat  <= flit_src;
        data_cnt <= 8'd0;
        err_acc  <= dest_bad ? ERR_DEST : ERR_NONE;
      end

      if (data_flit) begin
        data_cnt <= sat_inc(data_cnt);
        // Only the first error of a packet is kept.
        if (err_acc == ERR_NONE) begin
          if (data_bad)
            err_acc <= ERR_DATA;
          else if (data_cnt >= EXP_CNT)
            err_acc <= ERR_LONG;
        end
      end

      if (stray_flit)
        stray_num <= sat_inc(stray_num);

      if (end_pkt) begin
        if (HAS_STALL) begin
          state         <= S_STALL;
          receive_ready <= 1'b0;
          stall_cnt     <= STALL_LOAD;
        end else begin
          state <= S_IDLE;
        end
      end else if (open_pkt) begin
        state <= S_BODY;
      end else if (state == S_STALL) begin
        if (stall_cnt == 8'd0) begin
          state         <= S_IDLE;
          receive_ready <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt - 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
